// File: rtl/conv_ctrl_pkg.sv
// Shared types and size helpers for the conv2d layer controller.
// Coefficient counts are derived from the attached conv2d geometry.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_LOAD_B,
    ST_COMMIT,
    ST_READY,
    ST_WAIT,
    ST_HOLD
  } state_t;

  localparam int FRAME_CNT_W = 16;

  function automatic int calc_nw(input int num_filters, input int input_channels,
                                 input int kernel_size);
    return num_filters * input_channels * kernel_size * kernel_size;
  endfunction

  function automatic int calc_nb(input int num_filters);
    return num_filters;
  endfunction

endpackage

// File: rtl/conv_cfg_shadow.sv
// Shadow weight/bias registers written serially at a shared word counter.
// Raises last_weight/last_bias on the final slot of each section.
module conv_cfg_shadow
  import conv_ctrl_pkg::*;
#(
  parameter int NW = 18,
  parameter int NB = 2,
  parameter int W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            wr_en,
  input  logic            sel_bias,
  input  logic [W-1:0]    data,
  output logic [NW*W-1:0] weights,
  output logic [NB*W-1:0] biases,
  output logic            last_weight,
  output logic            last_bias
);

  localparam int CW = $clog2(((NW > NB) ? NW : NB) + 1);

  logic [CW-1:0] cnt;

  assign last_weight = (cnt == CW'(NW - 1));
  assign last_bias   = (cnt == CW'(NB - 1));

  // Counter rewinds after the last slot of either section.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (wr_en) begin
      if (sel_bias ? last_bias : last_weight) cnt <= '0;
      else                                    cnt <= cnt + 1'b1;
    end
  end

  // NOTE: the shadow array is reset on purpose: a reset must discard any
  // partial coefficient set, so this storage cannot be left as plain RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weights <= '0;
      biases  <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NW; i++)
        if (!sel_bias && cnt == CW'(i)) weights[i*W +: W] <= data;
      for (int i = 0; i < NB; i++)
        if (sel_bias && cnt == CW'(i)) biases[i*W +: W] <= data;
    end
  end

endmodule

// File: rtl/conv2d_layer_ctrl.sv
// Sequencer in front of one conv2d: serial coefficient load, one-shot commit,
// then one frame at a time with valid/ready handshakes and a WAIT timeout.
module conv2d_layer_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter  int NUM_FILTERS    = 32,
  parameter  int INPUT_CHANNELS = 1,
  parameter  int KERNEL_SIZE    = 3,
  parameter  int ACTIV_BITS     = 8,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int NW = calc_nw(NUM_FILTERS, INPUT_CHANNELS, KERNEL_SIZE),
  localparam int NB = calc_nb(NUM_FILTERS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [ACTIV_BITS-1:0]    cfg_data,
  input  logic                     frm_valid,
  output logic                     frm_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NW*ACTIV_BITS-1:0] conv_weights,
  output logic [NB*ACTIV_BITS-1:0] conv_biases,
  output logic                     conv_load,
  output logic                     conv_data_valid,
  input  logic                     conv_out_valid,
  output logic                     configured,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [FRAME_CNT_W-1:0]   frame_cnt
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_next;
  logic [TW-1:0] tcnt;
  logic          shadow_wr, last_weight, last_bias;
  logic          start_cfg, frame_acc, got_result, timed_out, result_taken;

  conv_cfg_shadow #(
    .NW (NW),
    .NB (NB),
    .W  (ACTIV_BITS)
  ) u_shadow (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (start_cfg),
    .wr_en       (shadow_wr),
    .sel_bias    (state == ST_LOAD_B),
    .data        (cfg_data),
    .weights     (conv_weights),
    .biases      (conv_biases),
    .last_weight (last_weight),
    .last_bias   (last_bias)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    cfg_ready    = 1'b0;
    frm_ready    = 1'b0;
    conv_load    = 1'b0;
    busy         = 1'b1;
    shadow_wr    = 1'b0;
    start_cfg    = 1'b0;
    frame_acc    = 1'b0;
    got_result   = 1'b0;
    timed_out    = 1'b0;
    result_taken = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (cfg_start) begin
          start_cfg  = 1'b1;
          state_next = ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        cfg_ready = 1'b1;
        shadow_wr = cfg_valid;
        if (cfg_valid && last_weight) state_next = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        cfg_ready = 1'b1;
        shadow_wr = cfg_valid;
        if (cfg_valid && last_bias) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        conv_load  = 1'b1;
        state_next = ST_READY;
      end
      ST_READY: begin
        busy = 1'b0;
        // A reload request takes precedence over a frame in the same cycle.
        if (cfg_start) begin
          start_cfg  = 1'b1;
          state_next = ST_LOAD_W;
        end else begin
          frm_ready = 1'b1;
          if (frm_valid) begin
            frame_acc  = 1'b1;
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (conv_out_valid) begin
          got_result = 1'b1;
          state_next = ST_HOLD;
        end else if (tcnt == T_LAST) begin
          timed_out  = 1'b1;
          state_next = ST_READY;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          result_taken = 1'b1;
          state_next   = ST_READY;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign conv_data_valid = frm_valid & frm_ready;

  // NOTE: sequential state uses non-blocking assignments only, so later
  // statements here override earlier ones without read-after-write hazards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      configured  <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
      out_valid   <= 1'b0;
      tcnt        <= '0;
    end else begin
      if (start_cfg) begin
        configured  <= 1'b0;
        timeout_err <= 1'b0;
        frame_cnt   <= '0;
      end
      if (conv_load) configured  <= 1'b1;
      if (timed_out) timeout_err <= 1'b1;
      if (frame_acc)              tcnt <= '0;
      else if (state == ST_WAIT)  tcnt <= tcnt + 1'b1;
      if (got_result) out_valid <= 1'b1;
      if (result_taken) begin
        out_valid <= 1'b0;
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_conv2d_layer_ctrl.sv
// Self-checking bench for conv2d_layer_ctrl: directed load/frame/timeout/collision
// cases plus randomized reloads and frames against a transaction-level model.
module tb_conv2d_layer_ctrl;

  localparam int NF = 2, IC = 1, KS = 3, AB = 8, TO = 16;
  localparam int NW = NF * IC * KS * KS;
  localparam int NB = NF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_start, cfg_valid, cfg_ready;
  logic [AB-1:0]     cfg_data;
  logic              frm_valid, frm_ready, out_valid, out_ready;
  logic [NW*AB-1:0]  conv_weights;
  logic [NB*AB-1:0]  conv_biases;
  logic              conv_load, conv_data_valid, conv_out_valid;
  logic              configured, busy, timeout_err;
  logic [15:0]       frame_cnt;

  conv2d_layer_ctrl #(
    .NUM_FILTERS    (NF),
    .INPUT_CHANNELS (IC),
    .KERNEL_SIZE    (KS),
    .ACTIV_BITS     (AB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_start       (cfg_start),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_data        (cfg_data),
    .frm_valid       (frm_valid),
    .frm_ready       (frm_ready),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .conv_weights    (conv_weights),
    .conv_biases     (conv_biases),
    .conv_load       (conv_load),
    .conv_data_valid (conv_data_valid),
    .conv_out_valid  (conv_out_valid),
    .configured      (configured),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .frame_cnt       (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: committed coefficient set and status, updated per transaction.
  logic [AB-1:0] exp_w [NW];
  logic [AB-1:0] exp_b [NB];
  logic          exp_cfgd;
  logic          exp_err;
  logic [15:0]   exp_fcnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int n = 0; n < NW; n++) exp_w[n] = '0;
    for (int n = 0; n < NB; n++) exp_b[n] = '0;
    exp_cfgd = 1'b0;
    exp_err  = 1'b0;
    exp_fcnt = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_ready"},  cfg_ready, 1'b0);
    check({tag, "_frm_ready"},  frm_ready, 1'b0);
    check({tag, "_out_valid"},  out_valid, 1'b0);
    check({tag, "_conv_load"},  conv_load, 1'b0);
    check({tag, "_cdv"},        conv_data_valid, 1'b0);
    check({tag, "_configured"}, configured, 1'b0);
    check({tag, "_busy"},       busy, 1'b0);
    check({tag, "_timeout"},    timeout_err, 1'b0);
    check({tag, "_frame_cnt"},  frame_cnt, 16'd0);
    check({tag, "_weights0"},   conv_weights == '0, 1'b1);
    check({tag, "_biases0"},    conv_biases == '0, 1'b1);
  endtask

  task automatic check_coeffs(input string tag);
    for (int n = 0; n < NW; n++) check({tag, "_weight"}, conv_weights[n*AB +: AB], exp_w[n]);
    for (int n = 0; n < NB; n++) check({tag, "_bias"}, conv_biases[n*AB +: AB], exp_b[n]);
  endtask

  // Issue cfg_start in IDLE/READY; optionally with a competing frame.
  task automatic start_cfg(input logic with_frame);
    cfg_start = 1'b1;
    frm_valid = with_frame;
    #1;
    check("start_no_cdv", conv_data_valid, 1'b0);
    step();
    cfg_start = 1'b0;
    frm_valid = 1'b0;
    exp_cfgd  = 1'b0;
    exp_err   = 1'b0;
    exp_fcnt  = '0;
    check("start_cfg_ready", cfg_ready, 1'b1);
    check("start_configured", configured, exp_cfgd);
    check("start_timeout", timeout_err, exp_err);
    check("start_frame_cnt", frame_cnt, exp_fcnt);
  endtask

  // mode 0: words n+1; mode 1: random. stall 0: none; 1: gap between words; 2: random gaps.
  task automatic load_words(input int count, input int mode, input int stall);
    logic [AB-1:0] v;
    int gaps;
    for (int n = 0; n < count; n++) begin
      gaps = (stall == 1 && n > 0) ? 1 : (stall == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        cfg_valid = 1'b0;
        cfg_data  = AB'($urandom);
        #1;
        check("stall_cfg_ready", cfg_ready, 1'b1);
        check("stall_no_load", conv_load, 1'b0);
        step();
      end
      v = (mode == 0) ? AB'(n + 1) : AB'($urandom_range(0, 255));
      if (n < NW) exp_w[n] = v;
      else        exp_b[n - NW] = v;
      cfg_valid = 1'b1;
      cfg_data  = v;
      #1;
      check("load_cfg_ready", cfg_ready, 1'b1);
      check("load_no_load", conv_load, 1'b0);
      step();
    end
    cfg_valid = 1'b0;
    if (count == NW + NB) begin
      check("commit_load", conv_load, 1'b1);
      check("commit_configured", configured, 1'b0);
      check("commit_busy", busy, 1'b1);
      check("commit_cfg_ready", cfg_ready, 1'b0);
      step();
      exp_cfgd = 1'b1;
      check("ready_load_low", conv_load, 1'b0);
      check("ready_configured", configured, exp_cfgd);
      check("ready_busy", busy, 1'b0);
      check("ready_frm_ready", frm_ready, 1'b1);
      check_coeffs("commit");
    end
  endtask

  // lat: WAIT cycle index at which conv_out_valid pulses (>= TO means never).
  task automatic do_frame(input int lat, input int hold, input logic poke_start);
    check("frm_ready_ready", frm_ready, 1'b1);
    frm_valid = 1'b1;
    #1;
    check("cdv_handshake", conv_data_valid, 1'b1);
    step();
    frm_valid = 1'b0;
    check("cdv_one_cycle", conv_data_valid, 1'b0);
    for (int i = 0; i < TO; i++) begin
      frm_valid      = 1'($urandom_range(0, 1));
      conv_out_valid = (i == lat);
      #1;
      check("wait_frm_ready", frm_ready, 1'b0);
      check("wait_cdv", conv_data_valid, 1'b0);
      check("wait_busy", busy, 1'b1);
      check("wait_out_valid", out_valid, 1'b0);
      check("wait_timeout", timeout_err, exp_err);
      step();
      conv_out_valid = 1'b0;
      frm_valid      = 1'b0;
      if (i == lat) break;
    end
    if (lat < TO) begin
      for (int h = 0; h < hold; h++) begin
        out_ready = 1'b0;
        cfg_start = poke_start && (h == 0);
        frm_valid = 1'b1;
        #1;
        check("hold_out_valid", out_valid, 1'b1);
        check("hold_frm_ready", frm_ready, 1'b0);
        check("hold_cdv", conv_data_valid, 1'b0);
        step();
        cfg_start = 1'b0;
        frm_valid = 1'b0;
        check("hold_cfg_ignored", cfg_ready, 1'b0);
        check("hold_configured", configured, exp_cfgd);
      end
      out_ready = 1'b1;
      #1;
      check("take_out_valid", out_valid, 1'b1);
      step();
      out_ready = 1'b0;
      exp_fcnt  = exp_fcnt + 16'd1;
      check("done_out_valid", out_valid, 1'b0);
      check("done_frame_cnt", frame_cnt, exp_fcnt);
      check("done_frm_ready", frm_ready, 1'b1);
    end else begin
      exp_err = 1'b1;
      check("to_timeout", timeout_err, exp_err);
      check("to_out_valid", out_valid, 1'b0);
      check("to_frame_cnt", frame_cnt, exp_fcnt);
      check("to_frm_ready", frm_ready, 1'b1);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    cfg_start      = 1'b0;
    cfg_valid      = 1'b0;
    cfg_data       = '0;
    frm_valid      = 1'b0;
    out_ready      = 1'b0;
    conv_out_valid = 1'b0;
    model_reset();
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Directed back-to-back load of 0x01..0x14.
    start_cfg(1'b0);
    load_words(NW + NB, 0, 0);
    check("bias_pack", conv_biases, 16'h1413);

    // Stalled load with the same words.
    start_cfg(1'b0);
    load_words(NW + NB, 0, 1);
    check("stall_bias_pack", conv_biases, 16'h1413);

    // Directed frame: result two cycles after handshake, held for five cycles.
    do_frame(1, 5, 1'b1);
    check("frame_cnt_one", frame_cnt, 16'd1);

    // conv_out_valid outside WAIT is ignored.
    conv_out_valid = 1'b1;
    step();
    conv_out_valid = 1'b0;
    check("stray_out_valid", out_valid, 1'b0);
    check("stray_busy", busy, 1'b0);

    // Timeout: no result ever comes back.
    do_frame(TO + 3, 0, 1'b0);
    check("to_frame_kept", frame_cnt, 16'd1);

    // Collision: cfg_start with frm_valid in READY, then complete the reload.
    start_cfg(1'b1);
    check("collide_busy", busy, 1'b1);
    load_words(NW + NB, 1, 0);

    // Reset after seven words of a new load.
    start_cfg(1'b0);
    load_words(7, 1, 0);
    cfg_valid = 1'b1;
    rst_n     = 1'b0;
    #1;
    cfg_valid = 1'b0;
    model_reset();
    check_reset_outputs("midload_reset");
    #2;
    rst_n = 1'b1;
    step();
    check_reset_outputs("after_reset");
    start_cfg(1'b0);
    load_words(NW + NB, 1, 2);

    // Randomized reloads and frames.
    for (int r = 0; r < 4; r++) begin
      start_cfg(1'($urandom_range(0, 1)));
      load_words(NW + NB, 1, int'($urandom_range(0, 2)));
      for (int f = 0; f < 6; f++)
        do_frame(int'($urandom_range(0, TO + 3)), int'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)));
      check_coeffs("rand_keep");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
